reg_cmd_slave: RTL and testbench

REG_CMD_SLAVE -- requirements
Module: reg_cmd_slave

---
 rtl/reg_cmd_slave.sv | 143 ++++++++++++++
 tb/tb_reg_cmd_slave.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/reg_cmd_slave.sv
// Register-mapped command slave: per-channel control/status words, W1C interrupt
// status with enable mask, and a fixed-latency pipelined read return path.
module reg_cmd_slave #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32,
    parameter int NUM_CH = 3,
    parameter int RD_LAT = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [1:0]               cmd,
    input  logic [ADDR_W-1:0]        cmd_addr,
    input  logic [DATA_W-1:0]        cmd_data_m2s,
    output logic [DATA_W-1:0]        cmd_data_s2m,
    output logic                     cmd_rvalid,
    output logic                     cmd_err,
    output logic [NUM_CH*DATA_W-1:0] ch_ctrl,
    input  logic [NUM_CH*DATA_W-1:0] ch_status,
    input  logic [NUM_CH-1:0]        ch_irq,
    output logic                     irq
);

    localparam int WORD_W = ADDR_W - 2;

    localparam logic [1:0] CMD_READ  = 2'b01;
    localparam logic [1:0] CMD_WRITE = 2'b10;
    localparam logic [1:0] CMD_RSVD  = 2'b11;

    // Word-index boundaries of the register map (byte address / 4).
    localparam logic [WORD_W-1:0] W_CTRL_LIMIT = WORD_W'(NUM_CH);
    localparam logic [WORD_W-1:0] W_STAT_BASE  = WORD_W'(4);
    localparam logic [WORD_W-1:0] W_STAT_LIMIT = WORD_W'(4 + NUM_CH);
    localparam logic [WORD_W-1:0] W_IRQ_STAT   = WORD_W'(8);
    localparam logic [WORD_W-1:0] W_IRQ_EN     = WORD_W'(9);

    logic [DATA_W-1:0]              ctrl_reg [NUM_CH];
    logic [NUM_CH-1:0]              irq_stat_reg;
    logic [NUM_CH-1:0]              irq_en_reg;
    logic                           err_reg;
    logic [RD_LAT-1:0]              pipe_valid_reg;
    logic [RD_LAT-1:0][DATA_W-1:0]  pipe_data_reg;

    logic [WORD_W-1:0] word_idx;
    logic [1:0]        ch_sel;
    logic              is_read;
    logic              is_write;
    logic              aligned;
    logic              hit_ctrl;
    logic              hit_stat;
    logic              hit_irq_stat;
    logic              hit_irq_en;
    logic              mapped;
    logic              access_err;
    logic              wr_ok;
    logic [NUM_CH-1:0] ctrl_we;
    logic [NUM_CH-1:0] w1c_mask;
    logic [NUM_CH-1:0] irq_stat_next;
    logic [DATA_W-1:0] rd_value;

    assign word_idx     = cmd_addr[ADDR_W-1:2];
    assign ch_sel       = cmd_addr[3:2];
    assign is_read      = (cmd == CMD_READ);
    assign is_write     = (cmd == CMD_WRITE);
    assign aligned      = (cmd_addr[1:0] == 2'b00);
    assign hit_ctrl     = (word_idx < W_CTRL_LIMIT);
    assign hit_stat     = (word_idx >= W_STAT_BASE) && (word_idx < W_STAT_LIMIT);
    assign hit_irq_stat = (word_idx == W_IRQ_STAT);
    assign hit_irq_en   = (word_idx == W_IRQ_EN);
    assign mapped       = hit_ctrl | hit_stat | hit_irq_stat | hit_irq_en;

    // IDLE never errors; reserved always does; accesses fail on bad address or STAT write.
    assign access_err = (cmd == CMD_RSVD) |
                        ((is_read | is_write) & (~aligned | ~mapped | (is_write & hit_stat)));
    assign wr_ok      = is_write & ~access_err;

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            assign ctrl_we[gi] = wr_ok & hit_ctrl & (ch_sel == 2'(gi));
            assign ch_ctrl[gi*DATA_W +: DATA_W] = ctrl_reg[gi];
        end
    endgenerate

    assign w1c_mask      = (wr_ok & hit_irq_stat) ? cmd_data_m2s[NUM_CH-1:0] : '0;
    // Event set is applied after the clear so a colliding event wins.
    assign irq_stat_next = (irq_stat_reg & ~w1c_mask) | ch_irq;

    // Read data reflects register state before this cycle's update; zero unless a good READ.
    always_comb begin
        rd_value = '0;
        if (is_read && !access_err) begin
            if (hit_ctrl) begin
                for (int i = 0; i < NUM_CH; i++) begin
                    if (ch_sel == 2'(i)) rd_value = ctrl_reg[i];
                end
            end else if (hit_stat) begin
                for (int i = 0; i < NUM_CH; i++) begin
                    if (ch_sel == 2'(i)) rd_value = ch_status[i*DATA_W +: DATA_W];
                end
            end else if (hit_irq_stat) begin
                rd_value = DATA_W'(irq_stat_reg);
            end else begin
                rd_value = DATA_W'(irq_en_reg);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) ctrl_reg[i] <= '0;
            irq_stat_reg <= '0;
            irq_en_reg   <= '0;
            err_reg      <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (ctrl_we[i]) ctrl_reg[i] <= cmd_data_m2s;
            end
            if (wr_ok && hit_irq_en) irq_en_reg <= cmd_data_m2s[NUM_CH-1:0];
            irq_stat_reg <= irq_stat_next;
            err_reg      <= access_err;
        end
    end

    // Read return shift line; the last stage drives the outputs directly.
    always_ff @(posedge clk) begin
        if (rst) begin
            pipe_valid_reg <= '0;
            pipe_data_reg  <= '0;
        end else begin
            pipe_valid_reg[0] <= is_read;
            pipe_data_reg[0]  <= rd_value;
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_valid_reg[i] <= pipe_valid_reg[i-1];
                pipe_data_reg[i]  <= pipe_data_reg[i-1];
            end
        end
    end

    assign cmd_rvalid   = pipe_valid_reg[RD_LAT-1];
    assign cmd_data_s2m = pipe_data_reg[RD_LAT-1];
    assign cmd_err      = err_reg;
    assign irq          = |(irq_stat_reg & irq_en_reg);

endmodule

// File: tb/tb_reg_cmd_slave.sv
// Drives one shared command stream into RD_LAT=2 and RD_LAT=3 instances and checks
// both against a byte-address-level register model with a per-cycle response history.
module tb_reg_cmd_slave;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  cmd;
    logic [7:0]  cmd_addr;
    logic [31:0] cmd_data_m2s;
    logic [95:0] ch_status;
    logic [2:0]  ch_irq;

    logic [31:0] d2_data, d3_data;
    logic        d2_rvalid, d3_rvalid, d2_err, d3_err, d2_irq, d3_irq;
    logic [95:0] d2_ctrl, d3_ctrl;

    reg_cmd_slave #(.ADDR_W(8), .DATA_W(32), .NUM_CH(3), .RD_LAT(2)) u_lat2 (
        .clk(clk), .rst(rst), .cmd(cmd), .cmd_addr(cmd_addr),
        .cmd_data_m2s(cmd_data_m2s), .cmd_data_s2m(d2_data), .cmd_rvalid(d2_rvalid),
        .cmd_err(d2_err), .ch_ctrl(d2_ctrl), .ch_status(ch_status), .ch_irq(ch_irq),
        .irq(d2_irq));

    reg_cmd_slave #(.ADDR_W(8), .DATA_W(32), .NUM_CH(3), .RD_LAT(3)) u_lat3 (
        .clk(clk), .rst(rst), .cmd(cmd), .cmd_addr(cmd_addr),
        .cmd_data_m2s(cmd_data_m2s), .cmd_data_s2m(d3_data), .cmd_rvalid(d3_rvalid),
        .cmd_err(d3_err), .ch_ctrl(d3_ctrl), .ch_status(ch_status), .ch_irq(ch_irq),
        .irq(d3_irq));

    always #5 clk = ~clk;

    localparam logic [1:0] IDLE = 2'b00, RD = 2'b01, WR = 2'b10, RSV = 2'b11;

    int n_cmp  = 0;
    int n_fail = 0;
    bit model_ready = 1'b0;

    // Model state: registers plus the response each command cycle produced.
    logic [31:0] m_ctrl [3];
    logic [2:0]  m_stat, m_en;
    logic        hv [4];
    logic [31:0] hd [4];
    logic        e_err;

    logic [7:0]  addr_tab [12];
    logic [95:0] st_fix;

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_resp(input logic [1:0] c, input logic [7:0] a, input logic [95:0] st,
                              output logic v, output logic [31:0] d, output logic e);
        int  ai;
        bit  mapped;
        bit  is_stat;
        ai      = int'(a);
        is_stat = (ai >= 16) && (ai < 16 + 12);
        mapped  = (ai % 4 == 0) && ((ai < 12) || is_stat || ai == 32 || ai == 36);
        e = (c == RSV) || ((c == RD || c == WR) && (!mapped || (c == WR && is_stat)));
        v = (c == RD);
        d = '0;
        if (v && !e) begin
            if (ai < 12)       d = m_ctrl[ai / 4];
            else if (is_stat)  d = st[((ai - 16) / 4) * 32 +: 32];
            else if (ai == 32) d = {29'd0, m_stat};
            else               d = {29'd0, m_en};
        end
    endtask

    // One command cycle: drive, predict, advance the model at the edge, return at negedge.
    task automatic cycle(input logic r, input logic [1:0] c, input logic [7:0] a,
                         input logic [31:0] d, input logic [2:0] iv, input logic [95:0] st);
        logic        v, e;
        logic [31:0] rd;
        rst = r; cmd = c; cmd_addr = a; cmd_data_m2s = d; ch_irq = iv; ch_status = st;
        model_resp(c, a, st, v, rd, e);
        @(posedge clk);
        if (r) begin
            for (int i = 0; i < 3; i++) m_ctrl[i] = '0;
            m_stat = '0; m_en = '0; e_err = 1'b0;
            for (int i = 0; i < 4; i++) begin hv[i] = 1'b0; hd[i] = '0; end
        end else begin
            for (int i = 3; i > 0; i--) begin hv[i] = hv[i-1]; hd[i] = hd[i-1]; end
            hv[0] = v; hd[0] = rd; e_err = e;
            if (c == WR && !e) begin
                if (a < 8'd12)       m_ctrl[a / 4] = d;
                else if (a == 8'd36) m_en = d[2:0];
                else if (a == 8'd32) m_stat = m_stat & ~d[2:0];
            end
            m_stat = m_stat | iv;
        end
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (model_ready) begin
            chk("lat2_rvalid", {95'd0, d2_rvalid}, {95'd0, hv[1]});
            chk("lat2_rdata",  {64'd0, d2_data},   {64'd0, hd[1]});
            chk("lat3_rvalid", {95'd0, d3_rvalid}, {95'd0, hv[2]});
            chk("lat3_rdata",  {64'd0, d3_data},   {64'd0, hd[2]});
            chk("lat2_err",    {95'd0, d2_err},    {95'd0, e_err});
            chk("lat3_err",    {95'd0, d3_err},    {95'd0, e_err});
            chk("lat2_ctrl",   d2_ctrl, {m_ctrl[2], m_ctrl[1], m_ctrl[0]});
            chk("lat3_ctrl",   d3_ctrl, {m_ctrl[2], m_ctrl[1], m_ctrl[0]});
            chk("lat2_irq",    {95'd0, d2_irq},    {95'd0, |(m_stat & m_en)});
            chk("lat3_irq",    {95'd0, d3_irq},    {95'd0, |(m_stat & m_en)});
        end
    end

    initial begin
        addr_tab[0] = 8'h00; addr_tab[1] = 8'h04; addr_tab[2]  = 8'h08; addr_tab[3]  = 8'h0C;
        addr_tab[4] = 8'h10; addr_tab[5] = 8'h14; addr_tab[6]  = 8'h18; addr_tab[7]  = 8'h1C;
        addr_tab[8] = 8'h20; addr_tab[9] = 8'h24; addr_tab[10] = 8'h28; addr_tab[11] = 8'h22;
        st_fix = {32'h33333333, 32'h22222222, 32'h11111111};

        cycle(1'b1, IDLE, 8'h00, 32'h0, 3'b000, 96'h0);
        model_ready = 1'b1;
        cycle(1'b1, IDLE, 8'h00, 32'h0, 3'b000, 96'h0);
        chk("reset_rvalid", {95'd0, d2_rvalid}, 96'd0);
        chk("reset_ctrl", d3_ctrl, 96'd0);
        chk("reset_irq", {95'd0, d2_irq}, 96'd0);

        // Write then read back with two-cycle latency.
        cycle(1'b0, WR, 8'h04, 32'hDEADBEEF, 3'b000, st_fix);
        chk("wr04_ctrl1", {64'd0, d2_ctrl[63:32]}, {64'd0, 32'hDEADBEEF});
        cycle(1'b0, RD, 8'h04, 32'h0, 3'b000, st_fix);
        chk("rd04_not_yet", {95'd0, d2_rvalid}, 96'd0);
        cycle(1'b0, IDLE, 8'h00, 32'h0, 3'b000, st_fix);
        chk("rd04_rvalid", {95'd0, d2_rvalid}, 96'd1);
        chk("rd04_data", {64'd0, d2_data}, {64'd0, 32'hDEADBEEF});
        cycle(1'b0, IDLE, 8'h00, 32'h0, 3'b000, st_fix);

        // Back-to-back reads of CTRL0, STAT0, IRQ_EN.
        cycle(1'b0, WR, 8'h00, 32'hA5A50001, 3'b000, st_fix);
        cycle(1'b0, WR, 8'h24, 32'hFFFFFFFD, 3'b000, st_fix);
        cycle(1'b0, RD, 8'h00, 32'h0, 3'b000, st_fix);
        cycle(1'b0, RD, 8'h10, 32'h0, 3'b000, st_fix);
        chk("b2b_first", {63'd0, d2_rvalid, d2_data}, {63'd0, 1'b1, 32'hA5A50001});
        cycle(1'b0, RD, 8'h24, 32'h0, 3'b000, st_fix);
        chk("b2b_second", {63'd0, d2_rvalid, d2_data}, {63'd0, 1'b1, 32'h11111111});
        cycle(1'b0, IDLE, 8'h00, 32'h0, 3'b000, st_fix);
        chk("b2b_third", {63'd0, d2_rvalid, d2_data}, {63'd0, 1'b1, 32'h00000005});
        cycle(1'b0, IDLE, 8'h00, 32'h0, 3'b000, st_fix);
        chk("b2b_done", {95'd0, d2_rvalid}, 96'd0);

        // Error accesses.
        cycle(1'b0, WR, 8'h10, 32'hFFFFFFFF, 3'b000, st_fix);
        chk("err_wr_stat", {95'd0, d2_err}, 96'd1);
        cycle(1'b0, RD, 8'h30, 32'h0, 3'b000, st_fix);
        chk("err_rd_unmapped", {95'd0, d2_err}, 96'd1);
        cycle(1'b0, RD, 8'h02, 32'h0, 3'b000, st_fix);
        chk("err_rd_misaligned", {95'd0, d2_err}, 96'd1);
        chk("err_rd30_data", {63'd0, d2_rvalid, d2_data}, {63'd0, 1'b1, 32'h0});
        cycle(1'b0, IDLE, 8'h00, 32'h0, 3'b000, st_fix);
        chk("err_rd02_data", {63'd0, d2_rvalid, d2_data}, {63'd0, 1'b1, 32'h0});
        chk("err_no_change", d2_ctrl, {32'h0, 32'hDEADBEEF, 32'hA5A50001});
        cycle(1'b0, RSV, 8'h00, 32'h12345678, 3'b000, st_fix);
        chk("err_rsvd", {95'd0, d2_err}, 96'd1);

        // Interrupt set, mask, W1C.
        cycle(1'b0, WR, 8'h24, 32'h1, 3'b000, st_fix);
        cycle(1'b0, IDLE, 8'h00, 32'h0, 3'b011, st_fix);
        chk("irq_set", {95'd0, d2_irq}, 96'd1);
        cycle(1'b0, RD, 8'h20, 32'h0, 3'b000, st_fix);
        cycle(1'b0, IDLE, 8'h00, 32'h0, 3'b000, st_fix);
        chk("irq_stat_3", {64'd0, d2_data}, 96'd3);
        cycle(1'b0, WR, 8'h20, 32'h1, 3'b000, st_fix);
        chk("irq_cleared", {95'd0, d2_irq}, 96'd0);
        cycle(1'b0, RD, 8'h20, 32'h0, 3'b000, st_fix);
        cycle(1'b0, IDLE, 8'h00, 32'h0, 3'b000, st_fix);
        chk("irq_stat_2", {64'd0, d2_data}, 96'd2);

        // Clear and event collide on bit 0: set wins.
        cycle(1'b0, WR, 8'h20, 32'h1, 3'b001, st_fix);
        chk("collide_irq", {95'd0, d2_irq}, 96'd1);
        cycle(1'b0, RD, 8'h20, 32'h0, 3'b000, st_fix);
        cycle(1'b0, IDLE, 8'h00, 32'h0, 3'b000, st_fix);
        chk("collide_stat", {64'd0, d2_data}, 96'd3);

        // Reset one cycle after a READ on the three-cycle instance.
        cycle(1'b0, WR, 8'h00, 32'h12345678, 3'b000, st_fix);
        cycle(1'b0, RD, 8'h00, 32'h0, 3'b000, st_fix);
        cycle(1'b1, WR, 8'h00, 32'hFFFFFFFF, 3'b111, st_fix);
        chk("midrst_outputs", {d3_ctrl[31:0], d3_data, 29'd0, d3_rvalid, d3_err, d3_irq}, 96'd0);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, IDLE, 8'h00, 32'h0, 3'b000, st_fix);
            chk("midrst_no_rvalid", {95'd0, d3_rvalid}, 96'd0);
        end
        cycle(1'b0, RD, 8'h00, 32'h0, 3'b000, st_fix);
        cycle(1'b0, IDLE, 8'h00, 32'h0, 3'b000, st_fix);
        cycle(1'b0, IDLE, 8'h00, 32'h0, 3'b000, st_fix);
        chk("midrst_ctrl_zero", {63'd0, d3_rvalid, d3_data}, {63'd0, 1'b1, 32'h0});

        // Randomized traffic, including occasional resets.
        for (int n = 0; n < 600; n++) begin
            int          k;
            int          sel;
            logic [1:0]  c;
            logic [7:0]  a;
            logic [2:0]  iv;
            k   = int'($urandom_range(0, 12));
            a   = (k == 12) ? 8'($urandom) : addr_tab[k];
            sel = int'($urandom_range(0, 9));
            c   = (sel < 4) ? RD : (sel < 7) ? WR : (sel < 9) ? IDLE : RSV;
            iv  = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b000;
            cycle(($urandom_range(0, 63) == 0), c, a, $urandom, iv,
                  {$urandom, $urandom, $urandom});
        end
        for (int i = 0; i < 4; i++) cycle(1'b0, IDLE, 8'h00, 32'h0, 3'b000, st_fix);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
